// File: rtl/dcache_pkg.sv
// Shared types and address/byte helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } dcache_state_t;

    function automatic logic [29:0] addr_idx(input logic [31:0] a, input int idx_w);
        logic [29:0] w;
        w = a[31:2];
        return w & ((30'd1 << idx_w) - 30'd1);
    endfunction

    function automatic logic [29:0] addr_tag(input logic [31:0] a, input int idx_w);
        logic [29:0] w;
        w = a[31:2];
        return w >> idx_w;
    endfunction

    function automatic logic [3:0] byte_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] rep_byte(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid bits (async clear), tags and byte-writable data words.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [31:0]      data_o,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    input  logic             fill_i,
    input  logic [TAG_W-1:0] wtag_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data are deliberately left unreset; valid gates their use.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx_i] <= wtag_i;
        end
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    data_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-through no-write-allocate data cache with req/ack memory port.
// Optional saturating hit/miss counters are enabled with DCACHE_STATS_EN.
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RE,
    input  logic                  WE,
    input  logic                  StSrc,
    input  logic                  LdSrc,
    input  logic [31:0]           A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  Stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    dcache_state_t state_q, state_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic             line_match;
    logic             hit;
    logic [31:0]      lane_sh;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic             arr_we;
    logic             arr_fill;
    logic [3:0]       arr_be;
    logic [31:0]      arr_wdata;

    assign idx        = IDX_W'(addr_idx(A, IDX_W));
    assign tag        = TAG_W'(addr_tag(A, IDX_W));
    assign line_match = line_valid && (line_tag == tag);
    assign hit        = RE && line_match;

    assign lane_sh = line_data >> {A[1:0], 3'b000};
    assign RD      = LdSrc ? {24'b0, lane_sh[7:0]} : line_data;

    assign st_be    = StSrc ? byte_be(A[1:0]) : 4'hF;
    assign st_wdata = StSrc ? rep_byte(WD[7:0]) : WD;
    assign mem_addr = {A[31:2], 2'b00};

    dcache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx_i   (idx),
        .valid_o (line_valid),
        .tag_o   (line_tag),
        .data_o  (line_data),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .wdata_i (arr_wdata),
        .fill_i  (arr_fill),
        .wtag_i  (tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (WE) begin
                    state_d = WRITE;
                end else if (RE && !hit) begin
                    state_d = FETCH;
                end
            end
            FETCH: if (mem_ack) state_d = IDLE;
            WRITE: if (mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall is gated by reset so an aborted miss releases the core at once.
    always_comb begin
        Stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_wdata = st_wdata;
        arr_fill  = 1'b0;
        arr_we    = 1'b0;
        arr_be    = st_be;
        arr_wdata = st_wdata;
        unique case (state_q)
            IDLE: begin
                Stall = rst_n && (WE || (RE && !hit));
            end
            FETCH: begin
                Stall     = 1'b1;
                mem_req   = 1'b1;
                mem_be    = 4'hF;
                arr_fill  = mem_ack;
                arr_we    = mem_ack;
                arr_be    = 4'hF;
                arr_wdata = mem_rdata;
            end
            WRITE: begin
                Stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                mem_be  = st_be;
                arr_we  = mem_ack && line_match;
            end
            default: begin
                Stall = 1'b0;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && hit && !WE && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (state_q == IDLE && state_d == FETCH && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
